systolic_matmul_stream: RTL and testbench

Output-stationary N_SIZE x N_SIZE systolic matrix-multiply engine that computes C = A(N x K) * B(K x N) for a run-time K of 1..K_MAX. Both inputs use valid/ready streaming and the block applies the input skew internally. It supports signed and unsigned operands and drains C row-by-row through a back-pressurable output stream. It is the next-generation multiply core that sits between the operand fetch logic and the result writeback in the accelerator datapath.

---
 rtl/systolic_matmul_stream.sv | 262 ++++++++++++++++++++++++++
 tb/tb_systolic_matmul_stream.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul_stream.sv
// Output-stationary N_SIZE x N_SIZE systolic matrix multiplier. Operands stream in
// through valid/ready, are skewed internally, and C is drained row by row.
module systolic_matmul_stream #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 4,
    parameter int K_MAX     = 16,
    parameter int ACCW      = 2*DATAWIDTH + $clog2(K_MAX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(K_MAX+1)-1:0]   cfg_k_len,
    input  logic                         cfg_signed,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_SIZE*DATAWIDTH-1:0]  in_a,
    input  logic [N_SIZE*DATAWIDTH-1:0]  in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_SIZE*ACCW-1:0]       out_row,
    output logic [$clog2(N_SIZE)-1:0]    out_row_idx,
    output logic                         out_last,
    output logic                         busy
);
    localparam int KW = $clog2(K_MAX+1);
    localparam int RW = $clog2(N_SIZE);
    localparam int FW = $clog2(2*N_SIZE);
    localparam int OW = DATAWIDTH + 1;
    localparam int PW = 2*OW;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t                   state_r;
    logic [KW-1:0]            k_len_r;
    logic [KW-1:0]            beat_cnt_r;
    logic                     signed_r;
    logic [FW-1:0]            flush_cnt_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     out_last_r;
    logic                     busy_r;
    logic [RW-1:0]            row_idx_r;
    logic [N_SIZE*ACCW-1:0]   out_row_r;

    logic                     in_fire_s;
    logic                     clear_s;
    logic                     signed_eff_s;
    logic [KW-1:0]            k_eff_s;
    logic [RW-1:0]            next_row_s;

    // Operands carry one extra bit so a single signed multiplier serves both modes.
    logic signed [OW-1:0]     a_ext_s  [N_SIZE];
    logic signed [OW-1:0]     b_ext_s  [N_SIZE];
    logic signed [OW-1:0]     a_feed_s [N_SIZE];
    logic signed [OW-1:0]     b_feed_s [N_SIZE];
    logic signed [OW-1:0]     pe_a_s   [N_SIZE][N_SIZE];
    logic signed [OW-1:0]     pe_b_s   [N_SIZE][N_SIZE];
    logic signed [PW-1:0]     prod_s   [N_SIZE][N_SIZE];
    logic signed [OW-1:0]     a_pipe_r [N_SIZE][N_SIZE];
    logic signed [OW-1:0]     b_pipe_r [N_SIZE][N_SIZE];
    logic signed [ACCW-1:0]   acc_r    [N_SIZE][N_SIZE];

    assign in_fire_s   = in_valid && in_ready_r;
    assign clear_s     = (state_r == DRAIN) && out_ready && out_last_r;
    assign next_row_s  = row_idx_r + RW'(1);
    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_row     = out_row_r;
    assign out_row_idx = row_idx_r;
    assign out_last    = out_last_r;
    assign busy        = busy_r;

    // Job config decode: the first beat uses the live cfg inputs
    always_comb begin
        if (cfg_k_len == KW'(0) || cfg_k_len > KW'(K_MAX)) begin
            k_eff_s = KW'(K_MAX);
        end else begin
            k_eff_s = cfg_k_len;
        end
        if (state_r == IDLE) begin
            signed_eff_s = cfg_signed;
        end else begin
            signed_eff_s = signed_r;
        end
    end

    // Operand extension; cycles without a handshake inject zeros
    always_comb begin
        for (int i = 0; i < N_SIZE; i++) begin
            a_ext_s[i] = '0;
            b_ext_s[i] = '0;
            if (in_fire_s) begin
                a_ext_s[i] = {signed_eff_s & in_a[i*DATAWIDTH+DATAWIDTH-1], in_a[i*DATAWIDTH +: DATAWIDTH]};
                b_ext_s[i] = {signed_eff_s & in_b[i*DATAWIDTH+DATAWIDTH-1], in_b[i*DATAWIDTH +: DATAWIDTH]};
            end else begin
                a_ext_s[i] = '0;
                b_ext_s[i] = '0;
            end
        end
    end

    assign a_feed_s[0] = a_ext_s[0];
    assign b_feed_s[0] = b_ext_s[0];

    for (genvar g = 1; g < N_SIZE; g++) begin : g_skew
        logic signed [OW-1:0] a_sh_r [g];
        logic signed [OW-1:0] b_sh_r [g];

        // g-stage delay line for row g of A and column g of B
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int d = 0; d < g; d++) begin
                    a_sh_r[d] <= '0;
                    b_sh_r[d] <= '0;
                end
            end else if (clear_s) begin
                for (int d = 0; d < g; d++) begin
                    a_sh_r[d] <= '0;
                    b_sh_r[d] <= '0;
                end
            end else begin
                a_sh_r[0] <= a_ext_s[g];
                b_sh_r[0] <= b_ext_s[g];
                for (int d = 1; d < g; d++) begin
                    a_sh_r[d] <= a_sh_r[d-1];
                    b_sh_r[d] <= b_sh_r[d-1];
                end
            end
        end

        assign a_feed_s[g] = a_sh_r[g-1];
        assign b_feed_s[g] = b_sh_r[g-1];
    end

    // PE input routing and products
    always_comb begin
        for (int i = 0; i < N_SIZE; i++) begin
            pe_a_s[i][0] = a_feed_s[i];
            pe_b_s[0][i] = b_feed_s[i];
            for (int j = 1; j < N_SIZE; j++) begin
                pe_a_s[i][j] = a_pipe_r[i][j-1];
                pe_b_s[j][i] = b_pipe_r[j-1][i];
            end
        end
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE; j++) begin
                prod_s[i][j] = PW'(pe_a_s[i][j]) * PW'(pe_b_s[i][j]);
            end
        end
    end

    // PE grid: one-cycle operand hops and wrapping accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    a_pipe_r[i][j] <= '0;
                    b_pipe_r[i][j] <= '0;
                    acc_r[i][j]    <= '0;
                end
            end
        end else if (clear_s) begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    a_pipe_r[i][j] <= '0;
                    b_pipe_r[i][j] <= '0;
                    acc_r[i][j]    <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    a_pipe_r[i][j] <= pe_a_s[i][j];
                    b_pipe_r[i][j] <= pe_b_s[i][j];
                    acc_r[i][j]    <= acc_r[i][j] + ACCW'(prod_s[i][j]);
                end
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            k_len_r     <= '0;
            beat_cnt_r  <= '0;
            signed_r    <= 1'b0;
            flush_cnt_r <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            row_idx_r   <= '0;
            out_row_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_fire_s) begin
                        k_len_r     <= k_eff_s;
                        signed_r    <= cfg_signed;
                        beat_cnt_r  <= KW'(1);
                        busy_r      <= 1'b1;
                        flush_cnt_r <= '0;
                        if (k_eff_s == KW'(1)) begin
                            state_r    <= FLUSH;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire_s) begin
                        beat_cnt_r <= beat_cnt_r + KW'(1);
                        if (beat_cnt_r + KW'(1) == k_len_r) begin
                            state_r    <= FLUSH;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                // Last product reaches PE(N-1,N-1) 2N-2 edges after the last beat
                FLUSH: begin
                    if (flush_cnt_r == FW'(2*N_SIZE-1)) begin
                        state_r     <= DRAIN;
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                        row_idx_r   <= '0;
                        for (int j = 0; j < N_SIZE; j++) begin
                            out_row_r[j*ACCW +: ACCW] <= acc_r[0][j];
                        end
                    end else begin
                        flush_cnt_r <= flush_cnt_r + FW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last_r) begin
                            state_r     <= IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            row_idx_r   <= '0;
                            out_row_r   <= '0;
                            busy_r      <= 1'b0;
                            in_ready_r  <= 1'b1;
                        end else begin
                            row_idx_r  <= next_row_s;
                            out_last_r <= (next_row_s == RW'(N_SIZE-1));
                            for (int j = 0; j < N_SIZE; j++) begin
                                out_row_r[j*ACCW +: ACCW] <= acc_r[next_row_s][j];
                            end
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_matmul_stream.sv
// Self-checking bench for systolic_matmul_stream: directed scenarios plus random jobs
// checked against a plain sum-of-products reference model.
module tb_systolic_matmul_stream;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int KM = 16;
    localparam int AW = 2*DW + 4;
    localparam int KW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [KW-1:0]     cfg_k_len;
    logic              cfg_signed;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_a;
    logic [N*DW-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic [N*AW-1:0]   out_row;
    logic [1:0]        out_row_idx;
    logic              out_last;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_beat_cyc = 0;
    int lat = 0;

    logic [DW-1:0] ma [KM][N];
    logic [DW-1:0] mb [KM][N];
    logic [AW-1:0] exp_c [N][N];
    logic [AW-1:0] got [N][N];
    logic [1:0]    got_idx [N];
    logic          got_last [N];

    systolic_matmul_stream #(.DATAWIDTH(DW), .N_SIZE(N), .K_MAX(KM)) dut (
        .clk(clk), .rst(rst), .cfg_k_len(cfg_k_len), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint ext(input logic [DW-1:0] x, input bit sg);
        if (sg) return longint'($signed(x));
        else return longint'(x);
    endfunction

    // C = A*B as plain sums, reduced modulo 2^AW
    task automatic model(input int k, input bit sg);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                for (int kk = 0; kk < k; kk++) s += ext(ma[kk][i], sg) * ext(mb[kk][j], sg);
                exp_c[i][j] = s[AW-1:0];
            end
        end
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N; i++) begin
                ma[kk][i] = DW'($urandom);
                mb[kk][i] = DW'($urandom);
            end
        end
    endtask

    task automatic send(input int nbeats, input int kcfg, input bit sg,
                        input int gap_after, input int gap_len, output bit gap_ok);
        int n;
        gap_ok = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            if (b == gap_after) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_a = (N*DW)'($urandom);
                    in_b = (N*DW)'($urandom);
                    if (in_ready !== 1'b1) gap_ok = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                in_a[i*DW +: DW] = ma[b][i];
                in_b[i*DW +: DW] = mb[b][i];
            end
            cfg_k_len  = (b == 0) ? KW'(kcfg) : KW'($urandom);
            cfg_signed = (b == 0) ? sg : 1'($urandom);
            n = 0;
            while (in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (in_ready !== 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL in_ready_timeout beat=%0d got=0 want=1", b);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 last_beat_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_a = (N*DW)'($urandom);
        in_b = (N*DW)'($urandom);
    endtask

    task automatic recv(input int stall_row, input int stall_len, output bit hold_ok);
        int n;
        logic [N*AW-1:0] held;
        hold_ok = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            n = 0;
            @(negedge clk);
            while (out_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (out_valid !== 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL out_valid_timeout row=%0d got=0 want=1", r);
                return;
            end
            if (r == 0) lat = cyc - last_beat_cyc;
            for (int j = 0; j < N; j++) got[r][j] = out_row[j*AW +: AW];
            got_idx[r] = out_row_idx;
            got_last[r] = out_last;
            if (r == stall_row) begin
                out_ready = 1'b0;
                held = out_row;
                repeat (stall_len) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_row !== held || out_row_idx !== 2'(r)) hold_ok = 1'b0;
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_row !== '0 || out_row_idx !== 2'd0 || out_last !== 1'b0
            || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=v%0b r%0h i%0d l%0b b%0b rdy%0b want=all zero",
                     out_valid, out_row, out_row_idx, out_last, busy, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got=rdy%0b busy%0b want=rdy1 busy0", in_ready, busy);
        end
    endtask

    task automatic test_identity;
        bit ok, hok;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                ma[k][i] = (i == k) ? 8'd1 : 8'd0;
                mb[k][i] = DW'(4*k + i + 1);
            end
        end
        model(4, 1'b0);
        send(4, 4, 1'b0, -1, 0, ok);
        recv(-1, 0, hok);
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL ident_latency got=%0d want=8", lat);
        end
        vectors++;
        if (got[2][0] !== 20'd9 || got[2][3] !== 20'd12) begin
            miscompares++;
            $display("FAIL ident_row2 got=%0d,%0d want=9,12", got[2][0], got[2][3]);
        end
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (got[r][j] !== exp_c[r][j]) begin
                    miscompares++;
                    $display("FAIL ident_c[%0d][%0d] got=%0d want=%0d", r, j, got[r][j], exp_c[r][j]);
                end
            end
            vectors++;
            if (got_idx[r] !== 2'(r) || got_last[r] !== (r == N-1)) begin
                miscompares++;
                $display("FAIL ident_idx_last row=%0d got=%0d/%0b want=%0d/%0b", r, got_idx[r], got_last[r], r, r == N-1);
            end
        end
    endtask

    task automatic test_signed;
        bit ok, hok;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++) begin
                    ma[k][i] = 8'hFF;
                    mb[k][i] = 8'hFD;
                end
            end
            model(2, m == 0);
            send(2, 2, m == 0, -1, 0, ok);
            recv(-1, 0, hok);
            vectors++;
            if (exp_c[1][2] !== ((m == 0) ? 20'd6 : 20'd129030)) begin
                miscompares++;
                $display("FAIL signed_model mode=%0d got=%0d want=%0d", m, exp_c[1][2], (m == 0) ? 6 : 129030);
            end
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    vectors++;
                    if (got[r][j] !== exp_c[r][j]) begin
                        miscompares++;
                        $display("FAIL signed_c mode=%0d [%0d][%0d] got=%0d want=%0d", m, r, j, got[r][j], exp_c[r][j]);
                    end
                end
            end
        end
    endtask

    task automatic test_bubbles;
        bit ok, hok;
        fill_random(3);
        model(3, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            send(3, 3, 1'b1, (pass == 0) ? -1 : 1, 2, ok);
            recv(-1, 0, hok);
            vectors++;
            if (ok !== 1'b1) begin
                miscompares++;
                $display("FAIL bubble_in_ready got=0 want=1");
            end
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    vectors++;
                    if (got[r][j] !== exp_c[r][j]) begin
                        miscompares++;
                        $display("FAIL bubble_c pass=%0d [%0d][%0d] got=%0d want=%0d", pass, r, j, got[r][j], exp_c[r][j]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok, hok;
        fill_random(4);
        model(4, 1'b0);
        send(4, 4, 1'b0, -1, 0, ok);
        recv(1, 5, hok);
        vectors++;
        if (hok !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold got=unstable want=stable");
        end
        for (int r = 0; r < N; r++) begin
            vectors++;
            if (got_idx[r] !== 2'(r)) begin
                miscompares++;
                $display("FAIL bp_order row=%0d got=%0d want=%0d", r, got_idx[r], r);
            end
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (got[r][j] !== exp_c[r][j]) begin
                    miscompares++;
                    $display("FAIL bp_c[%0d][%0d] got=%0d want=%0d", r, j, got[r][j], exp_c[r][j]);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle got=rdy%0b busy%0b v%0b want=rdy1 busy0 v0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, hok;
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < N; i++) begin
                ma[k][i] = 8'd1;
                mb[k][i] = 8'd1;
            end
        end
        send(KM, 0, 1'b0, -1, 0, ok);
        recv(-1, 0, hok);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (got[r][j] !== 20'd16) begin
                    miscompares++;
                    $display("FAIL b2b_k0_c[%0d][%0d] got=%0d want=16", r, j, got[r][j]);
                end
            end
        end
        fill_random(1);
        model(1, 1'b0);
        send(1, 1, 1'b0, -1, 0, ok);
        recv(-1, 0, hok);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (got[r][j] !== exp_c[r][j]) begin
                    miscompares++;
                    $display("FAIL b2b_k1_c[%0d][%0d] got=%0d want=%0d", r, j, got[r][j], exp_c[r][j]);
                end
            end
        end
    endtask

    task automatic test_rst_drain;
        bit ok, hok;
        int n;
        fill_random(2);
        send(2, 2, 1'b0, -1, 0, ok);
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_row !== '0 || out_row_idx !== 2'd0 || out_last !== 1'b0
            || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_drain_outputs got=v%0b i%0d l%0b b%0b rdy%0b want=all zero",
                     out_valid, out_row_idx, out_last, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_drain_partial got=1 want=0");
        end
        fill_random(1);
        model(1, 1'b1);
        send(1, 1, 1'b1, -1, 0, ok);
        recv(-1, 0, hok);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (got[r][j] !== exp_c[r][j]) begin
                    miscompares++;
                    $display("FAIL rst_new_job_c[%0d][%0d] got=%0d want=%0d", r, j, got[r][j], exp_c[r][j]);
                end
            end
        end
    endtask

    task automatic test_random;
        bit ok, hok, sg;
        int kcfg, keff, gap_at, gap_len, srow, slen;
        for (int t = 0; t < 8; t++) begin
            kcfg = int'($urandom_range(0, 31));
            keff = (kcfg == 0 || kcfg > KM) ? KM : kcfg;
            sg = 1'($urandom);
            gap_at = int'($urandom_range(0, keff));
            gap_len = int'($urandom_range(0, 3));
            srow = int'($urandom_range(0, N-1));
            slen = int'($urandom_range(0, 3));
            fill_random(keff);
            model(keff, sg);
            send(keff, kcfg, sg, gap_at, gap_len, ok);
            recv(srow, slen, hok);
            vectors++;
            if (lat !== 2*N || hok !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_timing job=%0d got=lat%0d hold%0b want=lat%0d hold1", t, lat, hok, 2*N);
            end
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    vectors++;
                    if (got[r][j] !== exp_c[r][j]) begin
                        miscompares++;
                        $display("FAIL rand_c job=%0d k=%0d s=%0b [%0d][%0d] got=%0d want=%0d",
                                 t, keff, sg, r, j, got[r][j], exp_c[r][j]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        cfg_k_len = '0;
        cfg_signed = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_identity();
        test_signed();
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_rst_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
